// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, reads the instruction port, and buffers
// {pc, inst} pairs in a small FIFO toward decode with redirect/flush and exit halt.
module fetch_stage #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] EXIT_INST  = 32'hC000_1073
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_instmem_addr,
  input  logic [31:0] io_instmem_inst,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_pc,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_pc,
  output logic [31:0] io_out_inst,
  output logic        io_halted
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc,     pc_nxt;
  logic [CNT_W-1:0] count,  count_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic             halted, halted_nxt;
  logic             fetch;
  logic             deq;

  logic [31:0] entry_pc   [DEPTH];
  logic [31:0] entry_inst [DEPTH];

  // Next-state logic; redirect overrides everything except reset.
  always_comb begin
    pc_nxt     = pc;
    count_nxt  = count;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    halted_nxt = halted;
    deq        = (count != '0) && io_out_ready;
    fetch      = !halted && !io_redirect_valid && ((count < CNT_W'(DEPTH)) || deq);

    if (io_redirect_valid) begin
      pc_nxt     = {io_redirect_pc[31:2], 2'b00};
      count_nxt  = '0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      halted_nxt = 1'b0;
    end else begin
      if (fetch) begin
        pc_nxt     = pc + 32'd4;
        wr_ptr_nxt = PTR_W'(wr_ptr + PTR_W'(1));
        if (io_instmem_inst == EXIT_INST) begin
          halted_nxt = 1'b1;
        end
      end
      if (deq) begin
        rd_ptr_nxt = PTR_W'(rd_ptr + PTR_W'(1));
      end
      count_nxt = CNT_W'(count + CNT_W'(fetch) - CNT_W'(deq));
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc     <= START_ADDR;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      halted <= 1'b0;
    end else begin
      pc     <= pc_nxt;
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      halted <= halted_nxt;
    end
  end

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge clock) begin
    if (fetch) begin
      entry_pc[wr_ptr]   <= pc;
      entry_inst[wr_ptr] <= io_instmem_inst;
    end
  end

  assign io_instmem_addr = pc;
  assign io_out_valid    = (count != '0);
  assign io_out_pc       = entry_pc[rd_ptr];
  assign io_out_inst     = entry_inst[rd_ptr];
  assign io_halted       = halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus a scoreboard
// of expected {pc, inst} entries popped at every decode handshake.
module tb_fetch_stage;

  localparam logic [31:0] EXIT    = 32'hC000_1073;
  localparam logic [31:0] NO_EXIT = 32'h0000_F000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr, inst;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        halted;

  logic [31:0] w_addr, w_inst, w_out_pc, w_out_inst;
  logic        w_out_valid, w_halted;

  logic [31:0] exit_addr;
  logic        mon_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] ea);
    return (a == ea) ? EXIT : ((a << 8) | 32'h0000_0013);
  endfunction

  assign inst   = mem_word(addr, exit_addr);
  assign w_inst = mem_word(w_addr, NO_EXIT);

  always #5 clock = ~clock;

  fetch_stage u_dut (
    .clock(clock), .reset(reset),
    .io_instmem_addr(addr), .io_instmem_inst(inst),
    .io_redirect_valid(redir_valid), .io_redirect_pc(redir_pc),
    .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_pc(out_pc), .io_out_inst(out_inst), .io_halted(halted)
  );

  fetch_stage #(.START_ADDR(32'hFFFF_FFF8)) u_wrap (
    .clock(clock), .reset(reset),
    .io_instmem_addr(w_addr), .io_instmem_inst(w_inst),
    .io_redirect_valid(1'b0), .io_redirect_pc(32'h0),
    .io_out_valid(w_out_valid), .io_out_ready(1'b1),
    .io_out_pc(w_out_pc), .io_out_inst(w_out_inst), .io_halted(w_halted)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        eh;
  } vec_t;

  entry_t sb[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [31:0] pc);
    entry_t e;
    e.pc   = pc;
    e.inst = mem_word(pc, exit_addr);
    sb.push_back(e);
  endtask

  // A handshake visible now completes at the coming edge; score it first.
  task automatic tick();
    entry_t e;
    if (mon_en && reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_deq: got pc %h expected no entry", out_pc);
      end else begin
        e = sb.pop_front();
        check("deq_pc", out_pc, e.pc);
        check("deq_inst", out_inst, e.inst);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
  endtask

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] ea, input logic eh);
    vec_t v;
    v.ready = r; v.redir = rd; v.rpc = rp;
    v.ev = ev; v.epc = epc; v.eaddr = ea; v.eh = eh;
    return v;
  endfunction

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Back-pressure for 5 cycles, two accepts, hold, then flush while full.
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h4,   1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8,   1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8,   1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8,   1'b0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   32'h8,   1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   32'hC,   1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10,  1'b0);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h10,  1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 32'h103, 1'b0, 32'h0,   32'h100, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h104, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 32'h108, 1'b0);

    reset = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
    out_ready = 1'b1; exit_addr = NO_EXIT; mon_en = 1'b1;

    // Reset state and streaming at full rate, plus the wrapping-start instance.
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) begin
        check("first_valid", 32'(out_valid), 32'h1);
        check("first_pc", out_pc, 32'h0);
      end
      check("wrap_valid", 32'(w_out_valid), 32'h1);
      check("wrap_pc", w_out_pc, 32'hFFFF_FFF8 + 32'(4 * k));
      check("wrap_inst", w_out_inst, mem_word(32'hFFFF_FFF8 + 32'(4 * k), NO_EXIT));
    end
    check("wrap_addr", w_addr, 32'h4);
    drain("stream");
    out_ready = 1'b0;

    // Table-driven back-pressure and redirect-while-full.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    push(32'h0); push(32'h4);
    for (int i = 0; i < 11; i++) begin
      out_ready   = vecs[i].ready;
      redir_valid = vecs[i].redir;
      redir_pc    = vecs[i].rpc;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d_addr", i), addr, vecs[i].eaddr);
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].eh));
      if (vecs[i].ev) check($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
    end
    redir_valid = 1'b0;
    push(32'h100); push(32'h104); push(32'h108);
    out_ready = 1'b1;
    drain("post_redirect");
    out_ready = 1'b0;

    // Exit instruction at 0x8: halt, hold PC, then resume on redirect.
    reset = 1'b0; exit_addr = 32'h8;
    tick();
    reset = 1'b1; out_ready = 1'b1;
    push(32'h0); push(32'h4); push(32'h8);
    drain("halt_drain");
    check("halt_set", 32'(halted), 32'h1);
    check("halt_addr", addr, 32'hC);
    check("halt_empty", 32'(out_valid), 32'h0);
    repeat (4) tick();
    check("halt_hold_addr", addr, 32'hC);
    check("halt_hold", 32'(halted), 32'h1);
    redir_valid = 1'b1; redir_pc = 32'h0;
    tick();
    redir_valid = 1'b0;
    check("resume_halted", 32'(halted), 32'h0);
    check("resume_addr", addr, 32'h0);
    check("resume_valid", 32'(out_valid), 32'h0);
    push(32'h0); push(32'h4); push(32'h8);
    drain("resume_drain");
    check("rehalt", 32'(halted), 32'h1);
    out_ready = 1'b0;

    // Reset while full and halted; a same-cycle redirect must be ignored.
    reset = 1'b0; exit_addr = 32'h4;
    tick();
    reset = 1'b1;
    tick(); tick();
    check("pre_reset_halted", 32'(halted), 32'h1);
    check("pre_reset_valid", 32'(out_valid), 32'h1);
    reset = 1'b0; redir_valid = 1'b1; redir_pc = 32'h200;
    tick();
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_addr", addr, 32'h0);
    check("midrst_halted", 32'(halted), 32'h0);
    reset = 1'b1; redir_valid = 1'b0; exit_addr = NO_EXIT;
    tick();
    check("after_rst_valid", 32'(out_valid), 32'h1);
    check("after_rst_pc", out_pc, 32'h0);
    check("after_rst_addr", addr, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of the Memory instruction port.
- Owns the PC and drives io_instmem_addr, captures io_instmem_inst, and buffers {pc, inst} pairs in a small FIFO toward decode.
- Decode consumes through a valid/ready handshake.
- Supports control-flow redirect with flush, and halts fetching on a designated exit instruction.

Parameters:
- START_ADDR, 32'h00000000, PC value after reset.
- DEPTH, 2, FIFO entries. Power of two, >= 2.
- EXIT_INST, 32'hC0001073, encoding that stops further fetch once enqueued.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low: state resets at a rising edge where reset==0.
- io_instmem_addr  output  32  fetch address to Memory; equals the PC register.
- io_instmem_inst  input  32  instruction word; combinational read of io_instmem_addr, valid in the same cycle.
- io_redirect_valid  input  1  branch/jump taken; flush and reload the PC.
- io_redirect_pc  input  32  redirect target; bits [1:0] are forced to 0.
- io_out_valid  output  1  head FIFO entry is valid.
- io_out_ready  input  1  decode accepts the head entry.
- io_out_pc  output  32  PC of the head entry.
- io_out_inst  output  32  instruction of the head entry.
- io_halted  output  1  EXIT_INST has been enqueued; fetch is stopped.

Behaviour:
- Reset values (reset==0 at an edge):
  - pc=START_ADDR, count=0, rd/wr pointers=0, halted=0.
  - Outputs: io_out_valid=0, io_halted=0, io_instmem_addr=START_ADDR.
  - io_out_pc / io_out_inst are don't-care while io_out_valid=0.
- Reset mid-operation discards all buffered entries and any pending redirect; the same-cycle redirect is ignored.
- io_instmem_addr = pc at all times, combinational from the register.
- deq = io_out_valid && io_out_ready.
- fetch = !halted && !io_redirect_valid && (count < DEPTH || deq).
  - Full FIFO with a simultaneous deq still fetches; count stays at DEPTH.
- On fetch:
  - Write {pc, io_instmem_inst} at wr_ptr; wr_ptr increments modulo DEPTH.
  - pc <= pc + 4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
  - If io_instmem_inst == EXIT_INST: halted <= 1 and the entry is still enqueued. The PC still advances, but no further fetch occurs.
- On deq: rd_ptr increments modulo DEPTH.
- Count update: count <= count + fetch - deq.
  - Simultaneous fetch and deq leaves count unchanged.
  - Empty FIFO: deq cannot occur; no bypass, so an instruction is visible no earlier than the cycle after its fetch.
- Latency: an instruction fetched in cycle N appears on io_out_* in cycle N+1 at the earliest.
- Throughput: 1 instruction per cycle while io_out_ready=1.
- Outputs: io_out_valid = (count != 0); io_out_pc / io_out_inst come from the entry at rd_ptr (registered storage).
- Redirect (io_redirect_valid=1) has highest priority:
  - count, rd_ptr and wr_ptr <= 0; halted <= 0; pc <= {io_redirect_pc[31:2], 2'b00}.
  - No enqueue that cycle. A deq in the same cycle is allowed (decode sees the handshake) but the entry is flushed regardless.
  - Next cycle: io_out_valid=0 and io_instmem_addr = redirect target.
- Halted state:
  - io_halted=1 until the next redirect or reset.
  - The FIFO continues to drain normally.
  - io_instmem_addr holds pc (EXIT address + 4).
- Back-pressure: while io_out_ready=0 and count==DEPTH, pc holds and io_out_* stay stable.
- No combinational path from io_out_ready or io_redirect_* to io_instmem_addr.

Test Plan:
- Reset released, memory words 0x00000013 at 0x0 to 0xC, io_out_ready=1 -> io_out_valid rises the cycle after release. io_out_pc shows 0x0, 0x4, 0x8, 0xC on consecutive cycles with inst 0x00000013.
- io_out_ready=0 for 5 cycles after reset -> count saturates at 2, io_instmem_addr holds 0x8, and head stays pc=0x0. Raise ready -> pcs 0x0, 0x4, 0x8 delivered back-to-back with no gap or duplicate.
- FIFO full and io_redirect_valid=1 with io_redirect_pc=0x103 -> next cycle io_out_valid=0 and io_instmem_addr=0x100. The cycle after, io_out_pc=0x100; no stale pc 0x0/0x4 ever appears.
- Memory word at 0x8 = 0xC0001073 -> entries 0x0, 0x4, 0x8 delivered, io_halted=1, and io_instmem_addr stays at 0xC indefinitely. Then redirect to 0x0 -> io_halted=0 and fetch resumes at 0x0.
- START_ADDR=32'hFFFFFFF8 -> pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
- Assert reset=0 for one cycle while count=2 and mid-stream -> next cycle io_out_valid=0, io_instmem_addr=START_ADDR, io_halted=0. A redirect asserted in that same cycle has no effect.
